// File: rtl/bus_pkg.sv
// Shared types and counter widths for the instruction/data bus scheduler.
package bus_pkg;

  localparam int unsigned WaitCntW  = 8;
  localparam int unsigned BurstCntW = 4;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_INSTR,
    GRANT_DATA
  } bus_state_t;

endpackage

// File: rtl/bus_watchdog.sv
// Counts wait states of the current grant and flags a timeout when the slave stalls too long.
module bus_watchdog
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic busy,
  input  logic ready,
  output logic timeout
);

  localparam logic [WaitCntW-1:0] Limit = WaitCntW'(TIMEOUT_CYCLES);

  logic [WaitCntW-1:0] wait_cnt_q, wait_cnt_d;

  // Saturate so a disabled watchdog never wraps back into a false match.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (start) begin
      wait_cnt_d = '0;
    end else if (busy && !ready && (wait_cnt_q != '1)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign timeout = (TIMEOUT_CYCLES != 0) && busy && !ready && (wait_cnt_q == Limit);

endmodule

// File: rtl/bus_scheduler.sv
// Arbitrates one multi-cycle memory bus between instruction fetch and load/store,
// data first with a burst limit, holding ownership until completion or watchdog abort.
module bus_scheduler
  import bus_pkg::*;
#(
  parameter int unsigned DATA_BURST_MAX = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr_address_in,
  input  logic        instr_read_in,
  output logic [31:0] instr_read_value_out,
  output logic        instr_ready,
  input  logic [31:0] data_address_in,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [3:0]  data_write_mask_in,
  input  logic [31:0] data_write_value_in,
  output logic [31:0] data_read_value_out,
  output logic        data_ready,
  output logic [31:0] address_out,
  output logic        read_out,
  output logic        write_out,
  output logic [3:0]  write_mask_out,
  output logic [31:0] write_value_out,
  input  logic [31:0] read_value_in,
  input  logic        mem_ready_in,
  output logic        bus_error_out
);

  localparam logic [BurstCntW-1:0] BurstMax = BurstCntW'(DATA_BURST_MAX);

  bus_state_t           state_q, state_d;
  logic [BurstCntW-1:0] burst_cnt_q, burst_cnt_d;
  logic                 data_req;
  logic                 timeout;
  logic                 wd_start;
  logic                 wd_busy;

  assign data_req = data_read_in | data_write_in;
  assign wd_start = (state_q == IDLE) && (state_d != IDLE);
  assign wd_busy  = (state_q != IDLE);

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (wd_start),
    .busy   (wd_busy),
    .ready  (mem_ready_in),
    .timeout(timeout)
  );

  always_comb begin
    state_d              = state_q;
    burst_cnt_d          = burst_cnt_q;
    address_out          = '0;
    read_out             = 1'b0;
    write_out            = 1'b0;
    write_mask_out       = '0;
    write_value_out      = '0;
    instr_read_value_out = '0;
    instr_ready          = 1'b0;
    data_read_value_out  = '0;
    data_ready           = 1'b0;
    bus_error_out        = 1'b0;

    case (state_q)
      IDLE: begin
        if (data_req && instr_read_in && (burst_cnt_q == BurstMax)) begin
          state_d     = GRANT_INSTR;
          burst_cnt_d = '0;
        end else if (data_req) begin
          state_d = GRANT_DATA;
          if (!instr_read_in) begin
            burst_cnt_d = '0;
          end else if (burst_cnt_q != '1) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end else if (instr_read_in) begin
          state_d     = GRANT_INSTR;
          burst_cnt_d = '0;
        end
      end
      GRANT_INSTR: begin
        address_out          = instr_address_in;
        read_out             = instr_read_in & ~timeout;
        instr_ready          = mem_ready_in | timeout;
        instr_read_value_out = timeout ? '0 : read_value_in;
        bus_error_out        = timeout;
        if (mem_ready_in || timeout) state_d = IDLE;
      end
      GRANT_DATA: begin
        address_out         = data_address_in;
        // A simultaneous read and write is illegal; the write takes the bus.
        read_out            = data_read_in & ~data_write_in & ~timeout;
        write_out           = data_write_in & ~timeout;
        write_mask_out      = data_write_mask_in;
        write_value_out     = data_write_value_in;
        data_ready          = mem_ready_in | timeout;
        data_read_value_out = timeout ? '0 : read_value_in;
        bus_error_out       = timeout;
        if (mem_ready_in || timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A transaction abandoned by reset must not complete or fault.
    if (!reset_n) begin
      instr_ready   = 1'b0;
      data_ready    = 1'b0;
      bus_error_out = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_scheduler.sv
// Directed bench for bus_scheduler: fetch, data priority, burst limit, watchdog, reset, illegal rw.
module tb_bus_scheduler;

  logic        clk;
  logic        reset_n;
  logic [31:0] instr_address_in;
  logic        instr_read_in;
  logic [31:0] instr_read_value_out;
  logic        instr_ready;
  logic [31:0] data_address_in;
  logic        data_read_in;
  logic        data_write_in;
  logic [3:0]  data_write_mask_in;
  logic [31:0] data_write_value_in;
  logic [31:0] data_read_value_out;
  logic        data_ready;
  logic [31:0] address_out;
  logic        read_out;
  logic        write_out;
  logic [3:0]  write_mask_out;
  logic [31:0] write_value_out;
  logic [31:0] read_value_in;
  logic        mem_ready_in;
  logic        bus_error_out;

  int n_checks;
  int n_errors;

  bus_scheduler #(
    .DATA_BURST_MAX(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .instr_address_in    (instr_address_in),
    .instr_read_in       (instr_read_in),
    .instr_read_value_out(instr_read_value_out),
    .instr_ready         (instr_ready),
    .data_address_in     (data_address_in),
    .data_read_in        (data_read_in),
    .data_write_in       (data_write_in),
    .data_write_mask_in  (data_write_mask_in),
    .data_write_value_in (data_write_value_in),
    .data_read_value_out (data_read_value_out),
    .data_ready          (data_ready),
    .address_out         (address_out),
    .read_out            (read_out),
    .write_out           (write_out),
    .write_mask_out      (write_mask_out),
    .write_value_out     (write_value_out),
    .read_value_in       (read_value_in),
    .mem_ready_in        (mem_ready_in),
    .bus_error_out       (bus_error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drop_all();
    instr_read_in       = 1'b0;
    data_read_in        = 1'b0;
    data_write_in       = 1'b0;
    data_write_mask_in  = '0;
    data_write_value_in = '0;
    mem_ready_in        = 1'b0;
    read_value_in       = '0;
  endtask

  logic [9:0] exp_order;
  logic [9:0] got_order;
  int         n_grants;

  initial begin
    n_checks         = 0;
    n_errors         = 0;
    reset_n          = 1'b0;
    instr_address_in = '0;
    data_address_in  = '0;
    drop_all();
    step();
    step();
    sample();
    check("rst_read", 32'(read_out), 32'd0);
    check("rst_write", 32'(write_out), 32'd0);
    check("rst_addr", address_out, 32'h0);
    check("rst_ready", {30'd0, instr_ready, data_ready}, 32'd0);
    check("rst_err", 32'(bus_error_out), 32'd0);
    step();
    reset_n = 1'b1;

    // Instruction only: grant in cycle 1, ready in cycle 3, IDLE in cycle 4.
    instr_read_in    = 1'b1;
    instr_address_in = 32'h100;
    sample();
    check("i_idle_read", 32'(read_out), 32'd0);
    step();
    sample();
    check("i_c1_addr", address_out, 32'h100);
    check("i_c1_read", 32'(read_out), 32'd1);
    check("i_c1_ready", 32'(instr_ready), 32'd0);
    step();
    sample();
    check("i_c2_read", 32'(read_out), 32'd1);
    step();
    mem_ready_in  = 1'b1;
    read_value_in = 32'hDEADBEEF;
    sample();
    check("i_c3_ready", 32'(instr_ready), 32'd1);
    check("i_c3_value", instr_read_value_out, 32'hDEADBEEF);
    check("i_c3_dvalue", data_read_value_out, 32'h0);
    check("i_c3_dready", 32'(data_ready), 32'd0);
    step();
    drop_all();
    sample();
    check("i_c4_read", 32'(read_out), 32'd0);
    check("i_c4_addr", address_out, 32'h0);

    // Data priority: store wins, then fetch after one IDLE cycle.
    instr_read_in       = 1'b1;
    instr_address_in    = 32'h104;
    data_write_in       = 1'b1;
    data_address_in     = 32'h2000;
    data_write_mask_in  = 4'b0011;
    data_write_value_in = 32'h1234;
    step();
    mem_ready_in = 1'b1;
    sample();
    check("d_addr", address_out, 32'h2000);
    check("d_write", 32'(write_out), 32'd1);
    check("d_read", 32'(read_out), 32'd0);
    check("d_mask", 32'(write_mask_out), 32'd3);
    check("d_wvalue", write_value_out, 32'h1234);
    check("d_ready", {30'd0, instr_ready, data_ready}, 32'd1);
    step();
    data_write_in = 1'b0;
    mem_ready_in  = 1'b0;
    sample();
    check("d_gap_read", 32'(read_out), 32'd0);
    check("d_gap_write", 32'(write_out), 32'd0);
    step();
    mem_ready_in  = 1'b1;
    read_value_in = 32'hCAFE0001;
    sample();
    check("d_i_addr", address_out, 32'h104);
    check("d_i_read", 32'(read_out), 32'd1);
    check("d_i_ready", {30'd0, instr_ready, data_ready}, 32'd2);
    check("d_i_value", instr_read_value_out, 32'hCAFE0001);
    step();
    drop_all();

    // Starvation limit with a zero-wait slave: D,D,D,D,I,D,D,D,D,I.
    exp_order       = 10'b10000_10000;
    got_order       = '0;
    n_grants        = 0;
    instr_read_in   = 1'b1;
    data_read_in    = 1'b1;
    data_address_in = 32'h2400;
    mem_ready_in    = 1'b1;
    read_value_in   = 32'h0BADF00D;
    for (int c = 0; c < 40 && n_grants < 10; c++) begin
      sample();
      if (instr_ready || data_ready) begin
        got_order[n_grants] = instr_ready;
        n_grants++;
      end
      if (n_grants < 10) step();
    end
    check("s_count", 32'(n_grants), 32'd10);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("s_grant%0d_is_instr", k), 32'(got_order[k]), 32'(exp_order[k]));
    end
    step();
    drop_all();

    // Watchdog: 8 silent wait cycles, abort in the 9th grant cycle.
    data_read_in    = 1'b1;
    data_address_in = 32'h3000;
    read_value_in   = 32'h55AA55AA;
    step();
    for (int c = 1; c <= 8; c++) begin
      sample();
      check($sformatf("w_c%0d_busy", c), {29'd0, read_out, data_ready, bus_error_out}, 32'd4);
      if (c < 8) step();
    end
    check("w_route", data_read_value_out, 32'h55AA55AA);
    step();
    sample();
    check("w_to_ready", 32'(data_ready), 32'd1);
    check("w_to_err", 32'(bus_error_out), 32'd1);
    check("w_to_value", data_read_value_out, 32'h0);
    check("w_to_read", 32'(read_out), 32'd0);
    step();
    data_read_in = 1'b0;
    sample();
    check("w_idle", {30'd0, read_out, bus_error_out}, 32'd0);

    // Ready arriving in the would-be timeout cycle is a normal completion.
    step();
    data_read_in = 1'b1;
    step();
    for (int c = 1; c < 9; c++) step();
    mem_ready_in = 1'b1;
    sample();
    check("w_late_ready", 32'(data_ready), 32'd1);
    check("w_late_err", 32'(bus_error_out), 32'd0);
    check("w_late_value", data_read_value_out, 32'h55AA55AA);
    step();
    drop_all();

    // Reset during data wait states, then a pending fetch.
    data_write_in       = 1'b1;
    data_address_in     = 32'h4000;
    data_write_mask_in  = 4'hF;
    data_write_value_in = 32'h77;
    step();
    step();
    reset_n          = 1'b0;
    data_write_in    = 1'b0;
    instr_read_in    = 1'b1;
    instr_address_in = 32'h200;
    mem_ready_in     = 1'b1;
    sample();
    check("r_no_pulse", {29'd0, instr_ready, data_ready, bus_error_out}, 32'd0);
    step();
    mem_ready_in = 1'b0;
    sample();
    check("r_strobes", {30'd0, read_out, write_out}, 32'd0);
    check("r_addr", address_out, 32'h0);
    check("r_mask_wv", {write_mask_out, write_value_out[27:0]}, 32'd0);
    check("r_pulses", {29'd0, instr_ready, data_ready, bus_error_out}, 32'd0);
    reset_n = 1'b1;
    #1;
    check("r_rel_idle", 32'(read_out), 32'd0);
    step();
    sample();
    check("r_fetch_addr", address_out, 32'h200);
    check("r_fetch_read", 32'(read_out), 32'd1);
    step();
    mem_ready_in = 1'b1;
    sample();
    check("r_fetch_ready", 32'(instr_ready), 32'd1);
    step();
    drop_all();

    // Illegal simultaneous read and write: write wins.
    data_read_in  = 1'b1;
    data_write_in = 1'b1;
    step();
    sample();
    check("x_rw", {30'd0, write_out, read_out}, 32'd2);
    step();
    mem_ready_in = 1'b1;
    sample();
    check("x_ready", 32'(data_ready), 32'd1);
    step();
    drop_all();
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
